// File: rtl/sine_phase_sequencer_pkg.sv
// Shared definitions for the sine generator front end: Q4.14 angle format,
// the pi/2 and 2*pi constants the CORDIC also uses, and the sequencer states.
package sine_phase_sequencer_pkg;

    // Q4.14 angle word and signed sample word widths.
    localparam int PHASE_W  = 18;
    localparam int SAMPLE_W = 16;
    localparam int SUM_W    = PHASE_W + 1;

    // pi/2 and 2*pi in Q4.14.
    localparam logic [PHASE_W-1:0] PI2    = 18'd25736;
    localparam logic [PHASE_W-1:0] TWO_PI = PHASE_W'(4 * PI2);

    // Sequencer states: waiting for a tick, issuing the start pulse, and
    // waiting out the CORDIC latency.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sine_phase_sequencer_phase_accum_wrap.sv
// phase_accum_wrap: y = (a + b) mod 2*pi for inputs already in [0, 2*pi).
// The 19-bit sum is compared before truncation, so one conditional
// subtract covers every legal input pair.
module phase_accum_wrap
    import sine_phase_sequencer_pkg::*;
(
    input  logic [PHASE_W-1:0] a,
    input  logic [PHASE_W-1:0] b,
    output logic [PHASE_W-1:0] y
);

    logic [SUM_W-1:0] sum;

    // Add, then fold back once by 2*pi; the 18-bit subtract is exact because
    // the wrapped result always fits in 18 bits.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, TWO_PI}) begin
            y = sum[PHASE_W-1:0] - TWO_PI;
        end else begin
            y = sum[PHASE_W-1:0];
        end
    end

endmodule

// File: rtl/sine_phase_sequencer.sv
// sine_phase_sequencer: phase accumulator and sample-rate pacing in front of
// cordic_sin. Each tick of the SAMPLE_DIV timer issues one CORDIC conversion,
// holds its angle for the whole conversion, and captures the result
// CORDIC_LAT cycles after the start pulse.
// Build macro: SINE_SEQ_PHASE_OFFSET_EN adds a phase_offset input that is
// added (mod 2*pi) to the angle sent to the CORDIC; the accumulator itself
// never sees the offset.
module sine_phase_sequencer
    import sine_phase_sequencer_pkg::*;
#(
    parameter int SAMPLE_DIV  = 32,
    parameter int CORDIC_LAT  = 20,
    // Clearing this lets a deliberately too-fast divider elaborate, which is
    // how back-to-back ticks during a conversion are exercised.
    parameter bit PARAM_CHECK = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [PHASE_W-1:0]         step_in,
`ifdef SINE_SEQ_PHASE_OFFSET_EN
    input  logic [PHASE_W-1:0]         phase_offset,
`endif
    input  logic signed [SAMPLE_W-1:0] cordic_out,
    output logic                       cordic_update,
    output logic [PHASE_W-1:0]         cordic_angle,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid,
    output logic                       overrun,
    output logic                       busy
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(CORDIC_LAT + 1);

    // A sample period shorter than one full conversion plus the return to
    // IDLE would drop every other tick.
    generate
        if (PARAM_CHECK && (SAMPLE_DIV < CORDIC_LAT + 2)) begin : g_bad_params
            $error("sine_phase_sequencer: SAMPLE_DIV must be >= CORDIC_LAT+2");
        end
    endgenerate

    seq_state_t         state;
    seq_state_t         state_next;
    logic [DIV_W-1:0]   divider;
    logic [CNT_W-1:0]   wait_cnt;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_next;
    logic [PHASE_W-1:0] issue_angle;
    logic [PHASE_W-1:0] angle_hold;
    logic               tick;
    logic               capture;

    // First enabled cycle ticks immediately since the divider rests at 0.
    assign tick = enable && (divider == '0);

    // Phase step, wrapped into [0, 2*pi).
    phase_accum_wrap u_phase_wrap (
        .a (phase),
        .b (step_in),
        .y (phase_next)
    );

`ifdef SINE_SEQ_PHASE_OFFSET_EN
    // Angle sent to the CORDIC carries the offset; the accumulator does not.
    phase_accum_wrap u_offset_wrap (
        .a (phase),
        .b (phase_offset),
        .y (issue_angle)
    );
`else
    assign issue_angle = phase;
`endif

    // Sample-rate divider: free-runs 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            divider <= '0;
        end else if (divider == DIV_W'(SAMPLE_DIV - 1)) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state strobes; enable is not consulted after the
    // tick, so a started conversion always runs to completion.
    always_comb begin
        state_next    = state;
        cordic_update = 1'b0;
        busy          = 1'b0;
        capture       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cordic_update = 1'b1;
                busy          = 1'b1;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == CNT_W'(CORDIC_LAT)) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Accumulator, held angle and latency counter; step_in/phase_offset are
    // only looked at in the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            angle_hold <= '0;
            wait_cnt   <= '0;
        end else if (state == ST_ISSUE) begin
            phase      <= phase_next;
            angle_hold <= issue_angle;
            wait_cnt   <= CNT_W'(1);
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Capture the CORDIC result and raise a one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= capture;
            if (capture) begin
                sample <= cordic_out;
            end
        end
    end

    // Sticky overrun: a tick that lands while a conversion is in flight is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (tick && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // The CORDIC reads the angle combinationally: present the new angle in the
    // ISSUE cycle and the registered copy for the rest of the conversion.
    always_comb begin
        cordic_angle = (state == ST_ISSUE) ? issue_angle : angle_hold;
    end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Bench for sine_phase_sequencer: three instances (sample periods 32, 22 and
// a too-fast 21) share random stimulus and are compared every cycle against
// a timestamp-based model of the sequencer, plus literal angle sequences.
module tb_sine_phase_sequencer;

    localparam int N      = 3;
    localparam int CL     = 20;
    localparam int TWO_PI = 102944;

    function automatic int sd_of(int g);
        return (g == 0) ? 32 : ((g == 1) ? 22 : 21);
    endfunction

    logic               clk        = 1'b0;
    logic               reset      = 1'b1;
    logic               enable     = 1'b0;
    logic [17:0]        step_in    = '0;
`ifdef SINE_SEQ_PHASE_OFFSET_EN
    logic [17:0]        phase_offset = '0;
`endif
    logic signed [15:0] cordic_out = '0;

    logic [N-1:0] upd, sv, ovr, bsy;
    logic [17:0]  ang [N];
    logic [15:0]  smp [N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model: conversion start time, held angle, captured sample, valid time.
    int m_phase [N];
    int m_cnt   [N];
    int m_last  [N];
    int m_angle [N];
    int m_sample[N];
    int m_vat   [N];
    int m_ovr   [N];

    int q_ang[$];
    int q_cyc[$];
    int sv0_first = -1;
    int upd0_cnt  = 0;
    int upd1_cnt  = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sine_phase_sequencer #(
            .SAMPLE_DIV  (sd_of(g)),
            .CORDIC_LAT  (CL),
            .PARAM_CHECK (sd_of(g) >= CL + 2)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .enable        (enable),
            .step_in       (step_in),
`ifdef SINE_SEQ_PHASE_OFFSET_EN
            .phase_offset  (phase_offset),
`endif
            .cordic_out    (cordic_out),
            .cordic_update (upd[g]),
            .cordic_angle  (ang[g]),
            .sample        (smp[g]),
            .sample_valid  (sv[g]),
            .overrun       (ovr[g]),
            .busy          (bsy[g])
        );
    end

    always #5 clk = ~clk;

    // Fresh random CORDIC result every cycle.
    always begin
        @(posedge clk);
        #1;
        cordic_out = 16'($urandom);
    end

    function automatic int off_eff();
`ifdef SINE_SEQ_PHASE_OFFSET_EN
        return int'(phase_offset);
`else
        return 0;
`endif
    endfunction

    task automatic check(string nm, int g, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d: got %0d, want %0d", nm, g, cyc, act, exp);
        end
    endtask

    // Model update: consumes the inputs of the cycle that just ended (cyc).
    always @(posedge clk) begin : model
        bit tick;
        bit infl;
        for (int g = 0; g < N; g++) begin
            if (reset) begin
                m_phase[g]  = 0;
                m_cnt[g]    = 0;
                m_last[g]   = -1000;
                m_angle[g]  = 0;
                m_sample[g] = 0;
                m_vat[g]    = -1;
                m_ovr[g]    = 0;
            end else begin
                infl = (cyc >= m_last[g]) && (cyc <= m_last[g] + CL);
                tick = enable && ((m_cnt[g] % sd_of(g)) == 0);
                m_cnt[g] = enable ? m_cnt[g] + 1 : 0;
                if (cyc == m_last[g]) begin
                    m_angle[g] = (m_phase[g] + off_eff()) % TWO_PI;
                    m_phase[g] = (m_phase[g] + int'(step_in)) % TWO_PI;
                end
                if (cyc == m_last[g] + CL) begin
                    m_sample[g] = int'(cordic_out);
                    m_vat[g]    = cyc + 1;
                end
                if (tick) begin
                    if (infl) m_ovr[g] = 1;
                    else      m_last[g] = cyc + 1;
                end
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin : compare
        int ea;
        if (chk_en) begin
            for (int g = 0; g < N; g++) begin
                ea = (cyc == m_last[g]) ? (m_phase[g] + off_eff()) % TWO_PI : m_angle[g];
                check("update",  g, int'(upd[g]), int'(cyc == m_last[g]));
                check("busy",    g, int'(bsy[g]), int'((cyc >= m_last[g]) && (cyc <= m_last[g] + CL)));
                check("valid",   g, int'(sv[g]),  int'(cyc == m_vat[g]));
                check("angle",   g, int'(ang[g]), ea);
                check("sample",  g, int'(smp[g]), m_sample[g] & 32'hFFFF);
                check("overrun", g, int'(ovr[g]), m_ovr[g]);
            end
        end
        if (upd[0]) begin
            q_ang.push_back(int'(ang[0]));
            q_cyc.push_back(cyc);
            upd0_cnt++;
        end
        if (sv[0] && sv0_first < 0) sv0_first = cyc;
        if (upd[1]) upd1_cnt++;
    end

    task automatic step_cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_upd(int n, int budget);
        int b = 0;
        while (q_ang.size() < n && b < budget) begin
            step_cycles(1);
            b++;
        end
        check("upd_timeout", 0, int'(q_ang.size() >= n), 1);
    endtask

    task automatic restart(int step);
        reset  = 1'b1;
        enable = 1'b0;
        step_cycles(2);
        q_ang.delete();
        q_cyc.delete();
        sv0_first = -1;
        step_in   = 18'(step);
        reset     = 1'b0;
        enable    = 1'b1;
    endtask

    initial begin : main
        int exp1[5] = '{0, 25736, 51472, 77208, 0};
        int exp2[5] = '{0, 30000, 60000, 90000, 17056};
        int snap;

        for (int g = 0; g < N; g++) begin
            m_phase[g] = 0; m_cnt[g] = 0; m_last[g] = -1000; m_angle[g] = 0;
            m_sample[g] = 0; m_vat[g] = -1; m_ovr[g] = 0;
        end

        // Reset state.
        step_cycles(3);
        chk_en = 1'b1;
        check("rst_angle",   0, int'(ang[0]), 0);
        check("rst_update",  0, int'(upd[0]), 0);
        check("rst_sample",  0, int'(smp[0]), 0);
        check("rst_valid",   0, int'(sv[0]),  0);
        check("rst_overrun", 0, int'(ovr[0]), 0);
        check("rst_busy",    0, int'(bsy[0]), 0);

        // Quarter-turn steps, 32-cycle spacing, 21-cycle latency.
        restart(25736);
        wait_upd(5, 200);
        if (q_ang.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("seq1_angle", i, q_ang[i], exp1[i]);
            for (int i = 0; i < 4; i++) check("seq1_space", i, q_cyc[i+1] - q_cyc[i], 32);
            check("latency", 0, sv0_first - q_cyc[0], 21);
        end

        // Step 30000 with wrap; period-22 instance never overruns, period-21 does.
        restart(30000);
        upd1_cnt = 0;
        wait_upd(5, 200);
        if (q_ang.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("seq2_angle", i, q_ang[i], exp2[i]);
        end
        step_cycles(40);
        check("div22_ticks",   1, int'(upd1_cnt >= 8), 1);
        check("div22_overrun", 1, int'(ovr[1]), 0);
        check("div21_overrun", 2, int'(ovr[2]), 1);
        enable = 1'b0;
        step_cycles(30);
        check("div21_sticky",  2, int'(ovr[2]), 1);

        // Enable dropped 5 cycles after update: sample still delivered, then
        // nothing until re-enable, which continues from the accumulated phase.
        restart(12345);
        check("ovr_cleared", 2, int'(ovr[2]), 0);
        wait_upd(1, 50);
        step_cycles(4);
        enable = 1'b0;
        snap = upd0_cnt;
        step_cycles(60);
        if (q_cyc.size() >= 1) check("drop_latency", 0, sv0_first - q_cyc[0], 21);
        check("drop_no_upd", 0, upd0_cnt - snap, 0);
        enable = 1'b1;
        wait_upd(2, 10);
        if (q_ang.size() >= 2) check("resume_angle", 0, q_ang[1], 12345);

        // Reset 10 cycles into a conversion: no sample, outputs back to zero.
        restart(20000);
        wait_upd(1, 50);
        step_cycles(9);
        reset     = 1'b1;
        enable    = 1'b0;
        sv0_first = -1;
        step_cycles(1);
        check("midrst_angle",  0, int'(ang[0]), 0);
        check("midrst_busy",   0, int'(bsy[0]), 0);
        check("midrst_sample", 0, int'(smp[0]), 0);
        reset = 1'b0;
        step_cycles(30);
        check("midrst_no_valid", 0, sv0_first, -1);

        // Random traffic: step changes every cycle, enable toggles, rare resets.
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step_in = 18'($urandom_range(0, 51471));
`ifdef SINE_SEQ_PHASE_OFFSET_EN
            phase_offset = 18'($urandom_range(0, TWO_PI - 1));
`endif
            if ($urandom_range(0, 99) < 3) enable = ~enable;
            reset = ($urandom_range(0, 599) == 0);
            step_cycles(1);
        end
        reset = 1'b0;

`ifdef SINE_SEQ_PHASE_OFFSET_EN
        // Offset applied to the angle only.
        phase_offset = 18'd90000;
        restart(25736);
        wait_upd(3, 120);
        if (q_ang.size() >= 3) begin
            check("offset_angle", 0, q_ang[0], 90000);
            check("offset_angle", 1, q_ang[1], 12792);
            check("offset_angle", 2, q_ang[2], 38528);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
